// File: rtl/pwm_meas_pkg.sv
// pwm_meas_pkg: shared constants and FSM encoding for the PWM duty meter and its divider.
package pwm_meas_pkg;
   localparam int DUTY_W = 7;
   localparam int DIV_STEPS = 7;
   localparam logic [DUTY_W-1:0] PCT_FULL = 7'd100;
   typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
endpackage

// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter_if: PWM input and measurement result bundle.
interface pwm_duty_meter_if #(
   parameter int CNT_W = 21
);
   logic pwm_i;
   logic [6:0] duty_o;
   logic [CNT_W-1:0] period_o;
   logic valid_o;
   logic stuck_o;
   modport master(output pwm_i, input duty_o, period_o, valid_o, stuck_o);
   modport slave(input pwm_i, output duty_o, period_o, valid_o, stuck_o);
endinterface

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: 7-step restoring divider; exact whenever the quotient is below 128.
module pwm_duty_div
   import pwm_meas_pkg::*;
#(
   parameter int CNT_W = 21
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [CNT_W+6:0]   num,
   input  logic [CNT_W-1:0]   den,
   output logic [DUTY_W-1:0]  q,
   output logic               busy,
   output logic               done
);
   localparam int NW = CNT_W + 7;
   logic [NW-1:0] rem;
   logic [NW-1:0] dsh;
   logic [DUTY_W-2:0] qr;
   logic [2:0] cnt;
   logic ge;
   assign ge = rem >= dsh;
   assign busy = cnt != 3'd0;
   assign done = cnt == 3'd1;
   // the last quotient bit is presented combinationally alongside done
   assign q = {qr, ge};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem <= '0;
         dsh <= '0;
         qr <= '0;
         cnt <= '0;
      end else if (start) begin
         rem <= num;
         dsh <= NW'({den, {(DIV_STEPS-1){1'b0}}});
         qr <= '0;
         cnt <= 3'(DIV_STEPS);
      end else if (busy) begin
         rem <= ge ? rem - dsh : rem;
         dsh <= dsh >> 1;
         qr <= {qr[DUTY_W-3:0], ge};
         cnt <= cnt - 3'd1;
      end
   end
endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures PWM period and rounded duty percent, with a stuck-input timeout.
module pwm_duty_meter
   import pwm_meas_pkg::*;
#(
   parameter int CNT_W = 21,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input logic clk,
   input logic reset_n,
   pwm_duty_meter_if.slave bus
);
   localparam int NW = CNT_W + 7;
   localparam logic [CNT_W-1:0] TO_HOLD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);
   logic s1, s2, s3, rise, lvl, to;
   logic [CNT_W-1:0] per_cnt, hi_cnt, cap_per, cap_hi, per_lat;
   logic armed, pend, start;
   logic [NW-1:0] num;
   logic [DUTY_W-1:0] q;
   logic busy, done;
   state_t state;
   logic [DUTY_W-1:0] duty_r;
   logic [CNT_W-1:0] period_r;
   logic valid_r, stuck_r;
   assign rise = s2 & ~s3;
   assign lvl = s2;
   // per_cnt parks one below the timeout, so the timeout fires once per stuck episode
   assign to = ~rise & (per_cnt == TO_FIRE);
   assign start = (state == IDLE) & pend & ~to;
   assign num = NW'(cap_hi) * NW'(PCT_FULL) + NW'(cap_per >> 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         per_cnt <= '0;
         hi_cnt <= '0;
         cap_per <= '0;
         cap_hi <= '0;
         armed <= 1'b0;
         pend <= 1'b0;
      end else begin
         s1 <= bus.pwm_i;
         s2 <= s1;
         s3 <= s2;
         per_cnt <= rise ? '0 : per_cnt + CNT_W'(per_cnt != TO_HOLD);
         hi_cnt <= rise ? '0 : hi_cnt + CNT_W'(lvl && hi_cnt != '1);
         armed <= rise | (armed & ~to);
         pend <= ~to & ((rise & armed) | (pend & ~start));
         if (rise & armed) begin
            cap_per <= per_cnt + 1'b1;
            cap_hi <= hi_cnt + 1'b1;
         end
      end
   end
   pwm_duty_div #(.CNT_W(CNT_W)) u_div (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .num(num),
      .den(cap_per),
      .q(q),
      .busy(busy),
      .done(done)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         duty_r <= '0;
         period_r <= '0;
         valid_r <= 1'b0;
         stuck_r <= 1'b0;
         per_lat <= '0;
      end else begin
         valid_r <= 1'b0;
         if (to) begin
            duty_r <= lvl ? PCT_FULL : '0;
            period_r <= '0;
            valid_r <= 1'b1;
            stuck_r <= 1'b1;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (pend) begin
                  per_lat <= cap_per;
                  state <= DIV;
               end
               DIV: if (done) begin
                  duty_r <= q;
                  period_r <= per_lat;
                  valid_r <= 1'b1;
                  stuck_r <= 1'b0;
                  state <= OUT;
               end else if (!busy) state <= IDLE;
               OUT: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
   assign bus.duty_o = duty_r;
   assign bus.period_o = period_r;
   assign bus.valid_o = valid_r;
   assign bus.stuck_o = stuck_r;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed and randomized PWM patterns checked against an arithmetic duty model.
module tb_pwm_duty_meter;
   localparam int CNT_W = 21;
   localparam int TO = 50;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   pwm_duty_meter_if #(.CNT_W(CNT_W)) bus();
   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {int duty; int per; int stuck; int t;} ent_t;
   ent_t q[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic prev_v = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // every result pulse is logged with its cycle stamp for later checking
   always @(negedge clk) begin
      if (bus.valid_o === 1'b1) begin
         chk("valid_gap", int'(prev_v), 0);
         q.push_back('{int'(bus.duty_o), int'(bus.period_o), int'(bus.stuck_o), cyc});
      end
      prev_v = bus.valid_o;
   end
   function automatic int exp_duty(input int per, input int hi);
      return (hi * 100 + per / 2) / per;
   endfunction
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic drive(input int per, input int hi);
      bus.pwm_i = 1'b1;
      wait_n(hi);
      bus.pwm_i = 1'b0;
      wait_n(per - hi);
   endtask
   task automatic run_cfg(input int per, input int hi, input int n, input bit end_high);
      int meas, dn, sp;
      q.delete();
      repeat (n) drive(per, hi);
      if (end_high) bus.pwm_i = 1'b1;
      wait_n(TO + 30);
      meas = end_high ? n : n - 1;
      dn = exp_duty(per, hi);
      if (per >= 9) chk("count", q.size(), meas + 1);
      else chk("count_min", int'(q.size() >= 2), 1);
      foreach (q[i]) begin
         if (i == q.size() - 1) begin
            chk("to_duty", q[i].duty, end_high ? 100 : 0);
            chk("to_period", q[i].per, 0);
            chk("to_stuck", q[i].stuck, 1);
         end else begin
            chk("duty", q[i].duty, dn);
            chk("period", q[i].per, per);
            chk("stuck", q[i].stuck, 0);
            if (i > 0) begin
               sp = q[i].t - q[i-1].t;
               if (per >= 9) chk("spacing", sp, per);
               else chk("spacing_rng", int'(sp >= 9 && sp <= 9 + per), 1);
            end
         end
      end
      if (end_high) begin
         bus.pwm_i = 1'b0;
         wait_n(3);
      end
   endtask
   initial begin
      int per, hi;
      bus.pwm_i = 1'b0;
      wait_n(3);
      chk("rst_duty", int'(bus.duty_o), 0);
      chk("rst_period", int'(bus.period_o), 0);
      chk("rst_valid", int'(bus.valid_o), 0);
      chk("rst_stuck", int'(bus.stuck_o), 0);
      reset_n = 1'b1;
      q.delete();
      wait_n(TO + 30);
      chk("low_to_count", q.size(), 1);
      if (q.size() == 1) begin
         chk("low_to_duty", q[0].duty, 0);
         chk("low_to_period", q[0].per, 0);
         chk("low_to_stuck", q[0].stuck, 1);
      end
      run_cfg(10, 3, 5, 1'b0);
      run_cfg(3, 1, 6, 1'b0);
      run_cfg(4, 2, 10, 1'b1);
      run_cfg(20, 7, 3, 1'b1);
      repeat (12) begin
         per = int'($urandom_range(40, 2));
         hi = int'($urandom_range(per - 1, 1));
         run_cfg(per, hi, int'($urandom_range(6, 3)), 1'($urandom_range(1, 0)));
      end
      // leave a stuck-high result in place, then reset in the middle of a division
      run_cfg(12, 5, 3, 1'b1);
      q.delete();
      drive(20, 7);
      bus.pwm_i = 1'b1;
      wait_n(5);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_duty", int'(bus.duty_o), 0);
      chk("mid_rst_period", int'(bus.period_o), 0);
      chk("mid_rst_valid", int'(bus.valid_o), 0);
      chk("mid_rst_stuck", int'(bus.stuck_o), 0);
      wait_n(1);
      reset_n = 1'b1;
      q.delete();
      wait_n(20);
      chk("no_valid_after_reset", q.size(), 0);
      bus.pwm_i = 1'b0;
      wait_n(13);
      bus.pwm_i = 1'b1;
      wait_n(20);
      bus.pwm_i = 1'b0;
      wait_n(TO + 30);
      chk("post_rst_count", q.size(), 2);
      if (q.size() == 2) begin
         chk("post_rst_duty", q[0].duty, exp_duty(33, 20));
         chk("post_rst_period", q[0].per, 33);
         chk("post_rst_stuck", q[0].stuck, 0);
         chk("post_rst_to_stuck", q[1].stuck, 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
